// File: rtl/fetch_cycle_pkg.sv
// rtl/fetch_cycle_pkg.sv - shared widths, NOP constant and fetch FSM states
package fetch_cycle_pkg;
    localparam int PC_W    = 18;
    localparam int INSTR_W = 33;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fd_pipe_reg.sv
// rtl/fd_pipe_reg.sv - Fetch/Decode pipeline register with load, bubble and hold
module fd_pipe_reg
    import fetch_cycle_pkg::*;
#(
    parameter int PC_W    = 18,
    parameter int INSTR_W = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic [PC_W-1:0]    PCPlus4D,
    output logic               ValidD
);

    // A bubble only replaces the instruction; PCD/PCPlus4D keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= INSTR_W'(NOP);
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (bubble) begin
            InstrD   <= INSTR_W'(NOP);
            ValidD   <= 1'b0;
        end else if (load) begin
            InstrD   <= instr;
            PCD      <= pc;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - instruction fetch stage: PC, fetch FSM, skid buffer, F/D register
module fetch_cycle
    import fetch_cycle_pkg::*;
#(
    parameter int              PC_W     = 18,
    parameter int              INSTR_W  = 33,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCSrcE,
    input  logic [PC_W-1:0]    PCTargetE,
    input  logic               StallD,
    input  logic               FlushD,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic [PC_W-1:0]    PCPlus4D,
    output logic               ValidD
);

    fetch_state_t       state, state_next;
    logic [PC_W-1:0]    pc, pc_next, pc_plus4, pc_redirect;
    logic [INSTR_W-1:0] skid;
    logic               skid_load;
    logic               fd_load, fd_bubble;
    logic [INSTR_W-1:0] fd_instr;

    assign pc_plus4    = pc + PC_W'(4);
    assign pc_redirect = PCTargetE & ~PC_W'(3);

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        skid_load  = 1'b0;
        fd_load    = 1'b0;
        fd_bubble  = 1'b0;
        fd_instr   = imem_rdata;

        if (PCSrcE) begin
            pc_next    = pc_redirect;
            fd_bubble  = 1'b1;
            state_next = FETCH;
        end else if (FlushD) begin
            // Any captured or arriving word is dropped; the same PC is re-fetched.
            fd_bubble  = 1'b1;
            state_next = FETCH;
        end else if (state == FETCH) begin
            if (imem_rvalid) begin
                if (StallD) begin
                    skid_load  = 1'b1;
                    state_next = HOLD;
                end else begin
                    fd_load = 1'b1;
                    pc_next = pc_plus4;
                end
            end else if (!StallD) begin
                fd_bubble = 1'b1;
            end
        end else begin
            if (!StallD) begin
                fd_instr   = skid;
                fd_load    = 1'b1;
                pc_next    = pc_plus4;
                state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            skid  <= INSTR_W'(NOP);
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (skid_load) begin
                skid <= imem_rdata;
            end
        end
    end

    fd_pipe_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fd_pipe_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (fd_load),
        .bubble   (fd_bubble),
        .instr    (fd_instr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

endmodule

// File: tb/tb_fetch_cycle.sv
// tb/tb_fetch_cycle.sv - directed and randomized check of fetch_cycle against a stream model
module tb_fetch_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [17:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [17:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [32:0] imem_rdata = '0;
    logic [32:0] InstrD;
    logic [17:0] PCD;
    logic [17:0] PCPlus4D;
    logic        ValidD;

    int vectors     = 0;
    int miscompares = 0;

    // Model: next address in program order, an optional captured-but-undelivered word,
    // and what Decode should currently be seeing.
    logic [17:0] m_pc;
    bit          m_have;
    logic [32:0] m_held;
    logic [32:0] m_instr;
    logic [17:0] m_pcd;
    logic [17:0] m_p4;
    bit          m_valid;
    bit          known = 1'b0;

    always #5 clk = ~clk;

    fetch_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    function automatic logic [32:0] mem_word(input logic [17:0] a);
        return {a[17:2] ^ 16'hA5C3, 1'b1, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic deliver(input logic [32:0] w);
        m_instr = w;
        m_pcd   = m_pc;
        m_p4    = m_pc + 18'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 18'd4;
    endtask

    task automatic drop_decode();
        m_instr = '0;
        m_valid = 1'b0;
    endtask

    task automatic cycle(input bit rv, input bit st, input bit fl, input bit ps,
                         input logic [17:0] tg, input bit r);
        rst         = r;
        imem_rvalid = rv;
        StallD      = st;
        FlushD      = fl;
        PCSrcE      = ps;
        PCTargetE   = tg;
        imem_rdata  = rv ? mem_word(imem_addr) : {1'b0, $urandom};
        #1;
        if (known) begin
            chk("imem_req", 64'(imem_req), 64'(!m_have));
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        end
        if (r) begin
            m_pc = 18'h0; m_have = 1'b0; m_held = '0;
            m_instr = '0; m_pcd = '0; m_p4 = '0; m_valid = 1'b0;
        end else if (ps) begin
            m_pc   = {tg[17:2], 2'b00};
            m_have = 1'b0;
            drop_decode();
        end else if (fl) begin
            m_have = 1'b0;
            drop_decode();
        end else if (m_have) begin
            if (!st) begin
                deliver(m_held);
                m_have = 1'b0;
            end
        end else if (rv && st) begin
            m_have = 1'b1;
            m_held = mem_word(m_pc);
        end else if (rv) begin
            deliver(mem_word(m_pc));
        end else if (!st) begin
            drop_decode();
        end
        @(posedge clk);
        #1;
        if (r) known = 1'b1;
        if (known) begin
            chk("InstrD", 64'(InstrD), 64'(m_instr));
            chk("PCD", 64'(PCD), 64'(m_pcd));
            chk("PCPlus4D", 64'(PCPlus4D), 64'(m_p4));
            chk("ValidD", 64'(ValidD), 64'(m_valid));
        end
    endtask

    initial begin
        cycle(0, 0, 0, 0, 18'h0, 1);
        cycle(1, 1, 1, 1, 18'h3FFFF, 1);
        chk("rst_req", 64'(imem_req), 64'd1);
        chk("rst_addr", 64'(imem_addr), 64'd0);

        cycle(1, 0, 0, 0, 18'h0, 0);
        cycle(1, 0, 0, 0, 18'h0, 0);
        chk("seq_pcd4", 64'(PCD), 64'd4);

        cycle(0, 0, 0, 0, 18'h0, 0);
        cycle(0, 0, 0, 0, 18'h0, 0);
        chk("wait_bubble", 64'(ValidD), 64'd0);
        cycle(1, 0, 0, 0, 18'h0, 0);
        chk("wait_instr8", 64'(InstrD), 64'(mem_word(18'd8)));
        chk("wait_pcd8", 64'(PCD), 64'd8);

        cycle(1, 1, 0, 0, 18'h0, 0);
        chk("hold_req", 64'(imem_req), 64'd0);
        cycle(1, 1, 0, 0, 18'h0, 0);
        cycle(1, 1, 0, 0, 18'h0, 0);
        cycle(0, 0, 0, 0, 18'h0, 0);
        chk("release_instr12", 64'(InstrD), 64'(mem_word(18'd12)));
        chk("release_pcd12", 64'(PCD), 64'd12);
        chk("release_addr16", 64'(imem_addr), 64'd16);

        cycle(1, 1, 0, 0, 18'h0, 0);
        cycle(1, 1, 0, 1, 18'h00103, 0);
        chk("redirect_valid", 64'(ValidD), 64'd0);
        chk("redirect_addr", 64'(imem_addr), 64'h100);

        cycle(0, 0, 0, 1, 18'h3FFFC, 0);
        cycle(1, 0, 0, 0, 18'h0, 0);
        chk("wrap_p4", 64'(PCPlus4D), 64'd0);
        chk("wrap_addr", 64'(imem_addr), 64'd0);

        cycle(1, 1, 1, 0, 18'h0, 0);
        chk("flush_valid", 64'(ValidD), 64'd0);
        chk("flush_addr", 64'(imem_addr), 64'd0);
        chk("flush_req", 64'(imem_req), 64'd1);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                  18'($urandom), $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_cycle.md
FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 Parameters (name, default, meaning): PC_W, 18, PC/address width; INSTR_W, 33, instruction width; RESET_PC, 18'h00000, PC after reset.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; all state updates on rising edge.
REQ-003 rst, in, 1, synchronous active-high reset, sampled on rising clk.
REQ-004 PCSrcE, in, 1, taken branch/jump resolved in Execute.
REQ-005 PCTargetE, in, PC_W, redirect target.
REQ-006 StallD, in, 1, hold F/D register and PC.
REQ-007 FlushD, in, 1, load bubble into F/D register.
REQ-008 imem_req, out, 1, fetch request.
REQ-009 imem_addr, out, PC_W, fetch address.
REQ-010 imem_rvalid, in, 1, imem_rdata valid for the address presented this cycle.
REQ-011 imem_rdata, in, INSTR_W, fetched instruction.
REQ-012 InstrD, out, INSTR_W, instruction to Decode.
REQ-013 PCD, out, PC_W, PC of InstrD.
REQ-014 PCPlus4D, out, PC_W, PCD+4.
REQ-015 ValidD, out, 1, InstrD is a real instruction (0 = bubble).

Function
REQ-016 Memory contract: memory samples imem_req/imem_addr every cycle, and rvalid answers the current cycle's address; the block abandons requests by changing address, and memory wait states appear as rvalid low.
REQ-017 FSM states: FETCH (imem_req=1, imem_addr=PC) and HOLD (imem_req=0, stalled instruction held in skid buffer).
REQ-018 PC[1:0] is always 2'b00; PCTargetE[1:0] is ignored; PC+4 wraps modulo 2^PC_W (18'h3FFFC+4 = 18'h00000).
REQ-019 Event priority per cycle: rst > PCSrcE > FlushD > StallD > normal.
REQ-020 PCSrcE=1 (any state): PC <= {PCTargetE[17:2],2'b00}; F/D <= bubble; skid buffer and any rvalid this cycle are discarded; next state FETCH.
REQ-021 FlushD=1, PCSrcE=0: F/D <= bubble; rvalid data this cycle is discarded and PC is unchanged; a HOLD buffer is discarded, and the next state is FETCH with PC unchanged (re-fetch).
REQ-022 FETCH, rvalid=1, StallD=0: F/D <= {imem_rdata, PC, PC+4, ValidD=1}; PC <= PC+4.
REQ-023 FETCH, rvalid=1, StallD=1: F/D holds; buffer <= imem_rdata; next state HOLD; PC unchanged.
REQ-024 FETCH, rvalid=0: if StallD=0, F/D <= bubble; if StallD=1, F/D holds; PC unchanged.
REQ-025 HOLD, StallD=1: everything holds; imem_req=0.
REQ-026 HOLD, StallD=0: F/D <= {buffer, PC, PC+4, 1}; PC <= PC+4; next state FETCH.
REQ-027 Bubble is InstrD=NOP (33'h0), ValidD=0, and PCD/PCPlus4D keep their previous values.
REQ-028 Latency: one instruction per cycle at zero wait states; the instruction fetched at edge N is visible on InstrD after edge N.
REQ-029 No instruction is duplicated or lost across any stall sequence.

Reset
REQ-030 While rst=1 at a clock edge: PC=RESET_PC, state=FETCH, InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0, and the skid buffer is cleared.
REQ-031 imem_req is 1 and imem_addr is RESET_PC in the first cycle after reset; rst overrides all other inputs, including mid-HOLD and mid-wait.

Structure
REQ-032 The shared package holds PC_W, INSTR_W, the NOP constant, and the fetch state enum (FETCH, HOLD).
REQ-033 One sub-module, fd_pipe_reg, holds the F/D register with load/bubble/hold controls; PC, FSM and skid buffer live in fetch_cycle.

Verification
REQ-034 Reset, then zero-wait memory, with data = address-tagged words -> imem_addr is 0, 4, 8, … on consecutive cycles; after edge N, PCD=4(N-1) with ValidD=1.
REQ-035 rvalid low for 2 cycles at PC=8 -> two bubbles (ValidD=0), then InstrD=mem[8], PCD=8, with no skip or duplicate.
REQ-036 StallD=1 for 3 cycles while rvalid=1 at PC=12 -> state goes to HOLD and imem_req=0; on release, InstrD=mem[12] and PCD=12; the next fetch address is 16.
REQ-037 PCSrcE=1 with PCTargetE=18'h00103 while in HOLD -> buffer discarded, ValidD=0, and next imem_addr=18'h00100.
REQ-038 PC=18'h3FFFC with rvalid -> PCPlus4D=0 and next imem_addr=0.
REQ-039 FlushD=1 with StallD=1 and rvalid=1 -> F/D bubble, PC unchanged, and the same address is re-fetched next cycle.
